// File: rtl/cmac_tx_gate.sv
// Gates the user TX AXI-Stream onto the CMAC tx_axis port, admitting traffic only while
// PCS alignment is stable and terminating in-flight frames with a bad-frame beat on loss.
module cmac_tx_gate #(
    parameter int DATA_WBITS    = 512,
    parameter int SYNC_STAGES   = 4,
    parameter int STABLE_CYCLES = 1024,
    parameter int ABORT_TIMEOUT = 64
) (
    input  logic                    tx_clk,
    input  logic                    sys_resetn_in,
    input  logic                    stat_rx_aligned,
    output logic                    ctl_tx_enable,
    output logic                    ctl_tx_send_rfi,
    output logic                    link_up,
    input  logic [DATA_WBITS-1:0]   s_axis_tdata,
    input  logic [DATA_WBITS/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [DATA_WBITS-1:0]   m_axis_tdata,
    output logic [DATA_WBITS/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [31:0]             dropped_packets,
    output logic [15:0]             aborted_packets
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(ABORT_TIMEOUT + 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LOAD    = TW'(ABORT_TIMEOUT);

    typedef enum logic [2:0] {
        ST_DOWN,
        ST_SETTLE,
        ST_PASS,
        ST_ABORT,
        ST_DISCARD
    } state_e;

    logic [1:0]             rst_sync_q;
    logic                   rst_n;
    logic [SYNC_STAGES-1:0] align_sync_q;
    logic                   sync_aligned;
    state_e                 state_q;
    logic                   in_pkt_q;
    logic [SW-1:0]          stable_cnt_q;
    logic [TW-1:0]          tmo_q;
    logic [31:0]            dropped_q;
    logic [15:0]            aborted_q;
    logic                   stable_done;
    logic                   abort_done;
    logic                   s_ready;
    logic                   m_valid;
    logic                   s_fire;
    logic                   is_abort;

    // NOTE: reset asserts asynchronously but releases on a clock edge, so no flop sees
    // a deassertion close to its active edge.
    always_ff @(posedge tx_clk or negedge sys_resetn_in) begin
        if (!sys_resetn_in) rst_sync_q <= '0;
        else                rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) align_sync_q <= '0;
        else        align_sync_q <= {align_sync_q[SYNC_STAGES-2:0], stat_rx_aligned};
    end
    assign sync_aligned = align_sync_q[SYNC_STAGES-1];

    assign stable_done = (stable_cnt_q == STABLE_LAST);
    assign abort_done  = (state_q == ST_ABORT) && (m_axis_tready || tmo_q == TW'(1));
    assign is_abort    = (state_q == ST_ABORT);

    // Handshake steering; in PASS this is a zero-latency combinational path.
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        case (state_q)
            ST_DOWN:    s_ready = 1'b1;
            ST_SETTLE:  s_ready = stable_done ? in_pkt_q : 1'b1;
            ST_PASS: begin
                if (sync_aligned) begin
                    s_ready = m_axis_tready;
                    m_valid = s_axis_tvalid;
                end
            end
            ST_ABORT:   m_valid = 1'b1;
            ST_DISCARD: s_ready = 1'b1;
            default: ;
        endcase
    end

    assign s_axis_tready = s_ready & sys_resetn_in & rst_n;
    assign m_axis_tvalid = m_valid & sys_resetn_in & rst_n;
    assign s_fire        = s_axis_tvalid & s_axis_tready;

    assign m_axis_tdata = is_abort ? '0   : s_axis_tdata;
    assign m_axis_tkeep = is_abort ? '1   : s_axis_tkeep;
    assign m_axis_tlast = is_abort ? 1'b1 : s_axis_tlast;
    assign m_axis_tuser = is_abort;

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) in_pkt_q <= 1'b0;
        else if (s_fire) in_pkt_q <= ~s_axis_tlast;
    end

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_DOWN;
            stable_cnt_q <= '0;
            tmo_q        <= '0;
        end else begin
            case (state_q)
                ST_DOWN: begin
                    if (sync_aligned) begin
                        state_q      <= ST_SETTLE;
                        stable_cnt_q <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (!sync_aligned)    state_q      <= ST_DOWN;
                    else if (!stable_done) stable_cnt_q <= stable_cnt_q + 1'b1;
                    else if (!in_pkt_q)   state_q      <= ST_PASS;
                end
                ST_PASS: begin
                    if (!sync_aligned) begin
                        state_q <= in_pkt_q ? ST_ABORT : ST_DOWN;
                        tmo_q   <= TMO_LOAD;
                    end
                end
                ST_ABORT: begin
                    if (abort_done) state_q <= ST_DISCARD;
                    else            tmo_q   <= tmo_q - 1'b1;
                end
                ST_DISCARD: begin
                    // Realignment is ignored here; only the source tlast ends the discard.
                    if (s_fire && s_axis_tlast) state_q <= ST_DOWN;
                end
                default: state_q <= ST_DOWN;
            endcase
        end
    end

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            dropped_q <= '0;
            aborted_q <= '0;
        end else begin
            if (s_fire && s_axis_tlast && dropped_q != '1 &&
                (state_q == ST_DOWN || (state_q == ST_SETTLE && !stable_done)))
                dropped_q <= dropped_q + 32'd1;
            if (abort_done && aborted_q != '1)
                aborted_q <= aborted_q + 16'd1;
        end
    end

    assign dropped_packets = dropped_q;
    assign aborted_packets = aborted_q;

    assign ctl_tx_enable   = (state_q == ST_PASS) || (state_q == ST_ABORT);
    assign ctl_tx_send_rfi = (state_q == ST_DOWN) || (state_q == ST_SETTLE);
    assign link_up         = (state_q == ST_PASS);

endmodule

// File: tb/tb_cmac_tx_gate.sv
// Scoreboard bench for cmac_tx_gate: the driver queues the beats that must appear on
// m_axis and an independent monitor pops and compares on every m_axis handshake.
module tb_cmac_tx_gate;

    localparam int DW  = 64;
    localparam int KW  = DW / 8;
    localparam int SS  = 4;
    localparam int STB = 16;
    localparam int TMO = 8;
    // Edges from raising stat_rx_aligned (DOWN, idle source) until link_up is visible.
    localparam int UP_EDGES = SS + 1 + STB;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    logic          tx_clk = 1'b0;
    logic          sys_resetn_in;
    logic          stat_rx_aligned;
    logic          ctl_tx_enable, ctl_tx_send_rfi, link_up;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tlast, s_axis_tvalid, s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast, m_axis_tuser, m_axis_tvalid, m_axis_tready;
    logic [31:0]   dropped_packets;
    logic [15:0]   aborted_packets;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    rdy_mode = 0;   // 0: always ready, 1: never ready, 2: random
    bit    quiet = 1'b0;   // m_axis must stay idle while set
    beat_t exp_q[$];

    cmac_tx_gate #(
        .DATA_WBITS(DW), .SYNC_STAGES(SS), .STABLE_CYCLES(STB), .ABORT_TIMEOUT(TMO)
    ) dut (
        .tx_clk(tx_clk), .sys_resetn_in(sys_resetn_in), .stat_rx_aligned(stat_rx_aligned),
        .ctl_tx_enable(ctl_tx_enable), .ctl_tx_send_rfi(ctl_tx_send_rfi), .link_up(link_up),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .dropped_packets(dropped_packets), .aborted_packets(aborted_packets)
    );

    always #5 tx_clk = ~tx_clk;

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge tx_clk);
        #1;
    endtask

    // Monitor: every m_axis handshake must match the oldest expected beat.
    always @(negedge tx_clk) begin
        beat_t got, e;
        if (quiet) check("m_idle", 80'(m_axis_tvalid), 80'd0);
        if (sys_resetn_in && m_axis_tvalid && m_axis_tready) begin
            got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got %0h expected none", got);
            end else begin
                e = exp_q.pop_front();
                check("m_beat", 80'(got), 80'(e));
            end
        end
    end

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge tx_clk);
            #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = 1'b0;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Offer one beat; when fwd is set it must appear unchanged on m_axis in the same cycle.
    task automatic send_beat(input bit last, input bit fwd);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        int n;
        d = {$urandom(), $urandom()};
        k = last ? KW'($urandom_range(1, (1 << KW) - 1)) : '1;
        n = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        if (fwd) exp_q.push_back({d, k, last, 1'b0});
        forever begin
            @(negedge tx_clk);
            if (fwd && n == 0) begin
                check("zero_lat_valid", 80'(m_axis_tvalid), 80'd1);
                check("ready_passthru", 80'(s_axis_tready), 80'(m_axis_tready));
            end
            if (s_axis_tready) break;
            n++;
            if (n > 200) begin
                fail_now("s_accept");
                break;
            end
        end
        @(posedge tx_clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int len, input bit fwd, input int idle_max);
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, idle_max)) @(posedge tx_clk);
            if (idle_max > 0) #1;
            send_beat(i == len - 1, fwd);
        end
    endtask

    // Waits for link_up; exp >= 0 also requires it after exactly exp edges.
    task automatic wait_link_up(input int exp);
        int n;
        n = 0;
        while (n < 80) begin
            @(posedge tx_clk);
            n++;
            @(negedge tx_clk);
            if (link_up) break;
        end
        if (!link_up) fail_now("link_up_wait");
        else if (exp >= 0) check("link_up_edges", 80'(n), 80'(exp));
        @(posedge tx_clk);
        #1;
    endtask

    initial begin
        int hold;
        bit pat_ok;
        logic [31:0] drop_snap;

        sys_resetn_in   = 1'b0;
        stat_rx_aligned = 1'b0;
        s_axis_tdata    = '0;
        s_axis_tkeep    = '0;
        s_axis_tlast    = 1'b0;
        s_axis_tvalid   = 1'b0;

        // Reset state
        tick(3);
        check("rst_s_tready", 80'(s_axis_tready), 80'd0);
        check("rst_m_tvalid", 80'(m_axis_tvalid), 80'd0);
        check("rst_ctl", 80'({ctl_tx_enable, ctl_tx_send_rfi, link_up}), 80'b010);
        check("rst_dropped", 80'(dropped_packets), 80'd0);
        sys_resetn_in = 1'b1;
        tick(3);

        // Link down: three packets dropped whole
        quiet = 1'b1;
        for (int p = 0; p < 3; p++) send_pkt(4, 1'b0, 0);
        tick(1);
        check("down_dropped", 80'(dropped_packets), 80'd3);
        check("down_rfi", 80'(ctl_tx_send_rfi), 80'd1);

        // Alignment rises mid-packet: tail drained, then traffic forwarded
        send_beat(1'b0, 1'b0);
        send_beat(1'b0, 1'b0);
        stat_rx_aligned = 1'b1;
        tick(30);
        check("drain_link_down", 80'(link_up), 80'd0);
        check("drain_tready", 80'(s_axis_tready), 80'd1);
        send_beat(1'b0, 1'b0);
        send_beat(1'b1, 1'b0);
        wait_link_up(-1);
        check("drain_not_counted", 80'(dropped_packets), 80'd3);
        quiet = 1'b0;
        check("pass_ctl", 80'({ctl_tx_enable, ctl_tx_send_rfi}), 80'b10);
        for (int p = 0; p < 3; p++) send_pkt($urandom_range(1, 5), 1'b1, 0);

        // Alignment lost between packets: clean return to DOWN, no abort beat
        stat_rx_aligned = 1'b0;
        quiet = 1'b1;
        repeat (SS) @(posedge tx_clk);
        @(negedge tx_clk);
        check("loss_still_pass", 80'(link_up), 80'd1);
        @(posedge tx_clk);
        @(negedge tx_clk);
        check("loss_down", 80'({link_up, ctl_tx_send_rfi}), 80'b01);
        check("loss_no_abort", 80'(aborted_packets), 80'd0);
        tick(1);
        stat_rx_aligned = 1'b1;
        wait_link_up(UP_EDGES);
        quiet = 1'b0;

        // Loss mid-packet, sink ready: one bad-frame beat, tail discarded
        drop_snap = dropped_packets;
        send_beat(1'b0, 1'b1);
        send_beat(1'b0, 1'b1);
        stat_rx_aligned = 1'b0;
        exp_q.push_back({{DW{1'b0}}, {KW{1'b1}}, 1'b1, 1'b1});
        tick(SS + 3);
        check("abort_beat_seen", 80'(exp_q.size()), 80'd0);
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) send_beat(1'b0, 1'b0);
        check("discard_ctl", 80'({ctl_tx_enable, ctl_tx_send_rfi, link_up}), 80'b000);
        send_beat(1'b1, 1'b0);
        @(negedge tx_clk);
        check("discard_to_down", 80'(ctl_tx_send_rfi), 80'd1);
        check("aborted_one", 80'(aborted_packets), 80'd1);
        check("discard_not_counted", 80'(dropped_packets), 80'(drop_snap));
        tick(1);

        // Loss mid-packet, sink stalled: abort beat held for the timeout, then withdrawn
        stat_rx_aligned = 1'b1;
        wait_link_up(UP_EDGES);
        quiet = 1'b0;
        send_beat(1'b0, 1'b1);
        send_beat(1'b0, 1'b1);
        rdy_mode = 1;
        m_axis_tready = 1'b0;
        stat_rx_aligned = 1'b0;
        hold = 0;
        pat_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge tx_clk);
            if (m_axis_tvalid) begin
                hold++;
                if (m_axis_tdata != '0 || m_axis_tkeep != '1 || !m_axis_tlast || !m_axis_tuser)
                    pat_ok = 1'b0;
            end
        end
        check("abort_hold_cycles", 80'(hold), 80'(TMO));
        check("abort_beat_stable", 80'(pat_ok), 80'd1);
        check("timeout_discard", 80'({ctl_tx_enable, ctl_tx_send_rfi}), 80'b00);
        check("aborted_two", 80'(aborted_packets), 80'd2);
        tick(1);
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) send_beat(i == 5, 1'b0);
        @(negedge tx_clk);
        check("timeout_to_down", 80'(ctl_tx_send_rfi), 80'd1);
        rdy_mode = 0;
        tick(1);

        // Glitch during SETTLE restarts the stable count
        stat_rx_aligned = 1'b1;
        tick(10);
        stat_rx_aligned = 1'b0;
        tick(2);
        stat_rx_aligned = 1'b1;
        wait_link_up(UP_EDGES);
        quiet = 1'b0;

        // Random back-pressure in PASS: nothing lost or duplicated
        rdy_mode = 2;
        for (int p = 0; p < 6; p++) send_pkt($urandom_range(1, 6), 1'b1, 2);
        rdy_mode = 0;
        tick(10);
        check("bp_queue_empty", 80'(exp_q.size()), 80'd0);

        // dropped_packets saturation
        stat_rx_aligned = 1'b0;
        tick(SS + 4);
        quiet = 1'b1;
        force dut.dropped_q = 32'hFFFF_FFFD;
        tick(1);
        release dut.dropped_q;
        for (int p = 0; p < 4; p++) send_pkt(2, 1'b0, 0);
        tick(1);
        check("dropped_saturate", 80'(dropped_packets), 80'hFFFF_FFFF);

        // Reset mid-packet: outputs clear at once, next packet treated as new
        stat_rx_aligned = 1'b1;
        wait_link_up(UP_EDGES);
        quiet = 1'b0;
        send_beat(1'b0, 1'b1);
        send_beat(1'b0, 1'b1);
        s_axis_tvalid = 1'b1;
        sys_resetn_in = 1'b0;
        #1;
        check("midrst_s_tready", 80'(s_axis_tready), 80'd0);
        check("midrst_m_tvalid", 80'(m_axis_tvalid), 80'd0);
        check("midrst_ctl", 80'({ctl_tx_enable, ctl_tx_send_rfi, link_up}), 80'b010);
        check("midrst_counters", 80'({dropped_packets, aborted_packets}), 80'd0);
        s_axis_tvalid = 1'b0;
        tick(3);
        sys_resetn_in = 1'b1;
        wait_link_up(-1);
        send_pkt(3, 1'b1, 0);
        tick(5);
        check("final_queue_empty", 80'(exp_q.size()), 80'd0);
        check("final_aborted", 80'(aborted_packets), 80'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cmac_tx_gate.md
Name: cmac_tx_gate

Overview:
- TX-side companion to the CMAC RX alignment controller. Sits between the user AXI-Stream TX source and the CMAC tx_axis port, in the tx_clk domain.
- Drives the CMAC tx control ports and passes traffic only while PCS alignment is stable. Packets are always admitted or dropped whole.
- If alignment is lost mid-packet, the in-flight frame is terminated with a bad-frame beat and the rest of the source packet is discarded. The source never stalls while the link is down.

Parameters:
- DATA_WBITS, 512, AXIS data width in bits (multiple of 8)
- SYNC_STAGES, 4, synchronizer flops on stat_rx_aligned (>=2)
- STABLE_CYCLES, 1024, consecutive synchronized-aligned cycles required before traffic is admitted (>=1)
- ABORT_TIMEOUT, 64, cycles to wait for CMAC acceptance of the abort beat before abandoning it (>=1)

Ports:
- tx_clk  in  1  CMAC tx_clk; all logic on rising edge
- sys_resetn_in  in  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronized internally to tx_clk
- stat_rx_aligned  in  1  CMAC PCS alignment, asynchronous; synchronized internally
- ctl_tx_enable  out  1  CMAC ctl_tx_enable
- ctl_tx_send_rfi  out  1  CMAC ctl_tx_send_rfi
- link_up  out  1  high while in PASS
- s_axis_tdata/tkeep/tlast/tvalid/tready  in/in/in/in/out  DATA_WBITS/DATA_WBITS/8/1/1/1  user TX stream
- m_axis_tdata/tkeep/tlast/tuser/tvalid/tready  out/out/out/out/out/in  DATA_WBITS/DATA_WBITS/8/1/1/1/1  to CMAC tx_axis
- dropped_packets  out  32  saturating count of whole packets discarded while down
- aborted_packets  out  16  saturating count of packets truncated by alignment loss

Behaviour:
- Reset (sys_resetn_in low): all flops clear asynchronously; state=DOWN, in_pkt=0, counters=0.
  - ctl_tx_enable=0, ctl_tx_send_rfi=1, link_up=0.
  - s_axis_tready=0 and m_axis_tvalid=0, gated directly by sys_resetn_in.
- sync_aligned is stat_rx_aligned after SYNC_STAGES flops (init 0).
- in_pkt register: set on an accepted source beat with tlast=0; cleared on an accepted source beat with tlast=1.
- DOWN:
  - s_tready=1, m_tvalid=0; beats are dropped.
  - dropped_packets+1 on each accepted tlast.
  - sync_aligned=1 -> SETTLE, stable counter=0.
- SETTLE:
  - sync_aligned=0 -> DOWN.
  - Stable counter increments each cycle. Until it reaches STABLE_CYCLES-1, behave as DOWN (dropping and counting).
  - Once reached, s_tready=in_pkt: only the tail of the current packet is drained and dropped.
  - When in_pkt=0 -> PASS. s_tready=0 in the transition cycle.
- PASS:
  - With sync_aligned=1, combinational pass-through and zero latency: m_tvalid=s_tvalid, s_tready=m_tready, data/keep/last forwarded, tuser=0.
  - With sync_aligned=0, that cycle has s_tready=0 and m_tvalid=0; next state is ABORT if in_pkt=1, else DOWN.
- ABORT:
  - Present one beat: m_tvalid=1, tdata=0, tkeep=all-ones, tlast=1, tuser=1. s_tready=0.
  - Timeout counter loads ABORT_TIMEOUT on entry.
  - m_tready=1 or timeout expiry -> DISCARD, aborted_packets+1 (increment in either case).
- DISCARD:
  - s_tready=1, m_tvalid=0; beats are dropped, not counted in dropped_packets.
  - Accepted tlast -> DOWN, regardless of sync_aligned.
- Output decode:
  - ctl_tx_enable=1 in PASS and ABORT only.
  - ctl_tx_send_rfi=1 in DOWN and SETTLE only.
  - link_up=1 in PASS only.
  - All three are registered, i.e. decoded from the state register.
- Counters hold at all-ones, with no wrap.
- Re-alignment during ABORT/DISCARD has no effect until DOWN is reached.
- m_axis output is AXIS-compliant: once m_tvalid rises in ABORT, the beat holds stable until accepted or the timeout expires. Timeout withdrawal is the only permitted exception, and is allowed because the CMAC is being disabled.
- Reset mid-packet: outputs clear immediately and in_pkt clears. The first post-reset packet is treated as new.

Test Plan:
- Reset with stat_rx_aligned=0, send 3 packets of 4 beats -> all beats accepted with s_tready=1, no m_tvalid, dropped_packets=3, ctl_tx_send_rfi=1.
- Raise stat_rx_aligned while mid-packet (beat 2 of 4), STABLE_CYCLES=16 -> that packet drained and dropped, link_up rises after tlast, next packet forwarded beat-for-beat with zero latency, ctl_tx_enable=1.
- In PASS, drop stat_rx_aligned between packets -> after SYNC_STAGES+1 cycles state is DOWN, no abort beat, aborted_packets=0.
- In PASS, drop alignment after beat 2 of an 8-beat packet with m_tready=1 -> one beat with tlast=1, tuser=1, tkeep all-ones; remaining 6 source beats dropped; aborted_packets=1; DOWN after source tlast.
- Same as previous but m_tready=0 throughout, ABORT_TIMEOUT=8 -> abort beat held exactly 8 cycles then withdrawn, DISCARD entered, aborted_packets=1.
- Alignment glitch shorter than STABLE_CYCLES during SETTLE, and back-pressure (m_tready toggling) in PASS -> SETTLE restarts from 0, no beat lost or duplicated, dropped_packets saturates at 0xFFFFFFFF when preloaded via force.
